ifetch_ctrl: RTL

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

---
 rtl/ifetch_pkg.sv | 19 +
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch_ctrl.sv | 116 +++++++++++
 3 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and helpers for the instruction-fetch controller and its fetch buffer.
package ifetch_pkg;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    // Written as pc < limit-3 so that a pc near 2^64 cannot wrap back into range.
    function automatic logic pc_fetchable(input logic [63:0] pc, input logic [63:0] mem_bytes);
        return (pc[1:0] == 2'b00) && (pc < (mem_bytes - 64'd3));
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Small fetch buffer: DEPTH entries, pointers with a wrap bit, flush empties it in one edge.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   wr_ptr_reg, rd_ptr_reg;
    logic [AW-1:0] wr_idx, rd_idx;
    fetch_entry_t  mem [DEPTH];

    assign wr_idx = wr_ptr_reg[AW-1:0];
    assign rd_idx = rd_ptr_reg[AW-1:0];
    assign empty  = (wr_ptr_reg == rd_ptr_reg);
    assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_idx == rd_idx);
    assign count  = wr_ptr_reg - rd_ptr_reg;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && !flush && (wr_idx == AW'(gi))) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Head is masked so an empty buffer never exposes stale entries.
    assign dout = empty ? '0 : mem[rd_idx];

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: PC/state logic feeding a fetch buffer toward decode.
// Optional IFETCH_STATS_EN adds saturating fetched/flushed counters.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 1024,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    output logic        fault
`ifdef IFETCH_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_flushed
`endif
);
    localparam logic [63:0] MEM_LIMIT = 64'(MEM_BYTES);
    localparam int          CW        = $clog2(BUF_DEPTH) + 1;

    state_t       state_reg, state_next;
    logic [63:0]  pc_reg, pc_next;
    logic         push, pop, flush;
    logic         full, empty;
    logic [CW-1:0] count;
    fetch_entry_t wr_entry, head;

    assign imem_addr = pc_reg;
    assign wr_entry  = '{pc: pc_reg, instr: imem_instr};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= RUN;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    // Redirect wins over everything except reset; bad PCs fault instead of pushing.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;
        if (redirect_valid) begin
            flush      = 1'b1;
            pc_next    = redirect_pc;
            state_next = RUN;
        end else begin
            pop = !empty && out_ready;
            if (state_reg == RUN) begin
                if (pc_fetchable(pc_reg, MEM_LIMIT)) begin
                    if (!full || pop) begin
                        push    = 1'b1;
                        pc_next = pc_reg + 64'd4;
                    end
                end else begin
                    state_next = FAULT;
                end
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (wr_entry),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign out_valid = (count != '0);
    assign out_instr = head.instr;
    assign out_pc    = head.pc;
    assign fault     = (state_reg == FAULT);

`ifdef IFETCH_STATS_EN
    logic [31:0] fetched_reg, flushed_reg;
    logic [32:0] flushed_sum;

    assign flushed_sum = {1'b0, flushed_reg} + 33'(count);

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_reg <= '0;
            flushed_reg <= '0;
        end else begin
            if (push && (fetched_reg != '1)) fetched_reg <= fetched_reg + 32'd1;
            if (flush) flushed_reg <= flushed_sum[32] ? '1 : flushed_sum[31:0];
        end
    end

    assign stat_fetched = fetched_reg;
    assign stat_flushed = flushed_reg;
`endif

endmodule
